// File: rtl/store_sequencer_if.sv
// Request/response and store-pin bundle for the store sequencer.
// master = control-unit/store side, slave = sequencer side.
interface store_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [4:0]  store_A;
  logic [31:0] store_D;
  logic        store_CS_n;
  logic        store_WE_n;
  logic        store_OE_n;
  logic [31:0] store_Q;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, store_Q,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  store_A, store_D, store_CS_n, store_WE_n, store_OE_n
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, store_Q,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output store_A, store_D, store_CS_n, store_WE_n, store_OE_n
  );
endinterface

// File: rtl/store_sequencer.sv
// Single-word store access sequencer: setup / strobe / hold / done
// sequence on the 32x32 store lines, all pins driven from flops.
module store_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input logic              clk,
  input logic              reset,
  store_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, DONE
  } state_t;

  localparam logic [3:0] S_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] T_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cs_n_q, cs_n_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        rsp_q, rsp_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cs_n_d  = cs_n_q;
    we_n_d  = we_n_q;
    oe_n_d  = oe_n_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    rsp_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_write;
          addr_d  = bus.req_addr;
          data_d  = bus.req_wdata;
          cs_n_d  = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = S_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = T_LD;
          we_n_d  = ~op_q;
          oe_n_d  = op_q;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = H_LD;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = HOLD;
          // OE_n is still low on this edge, so store_Q is valid
          if (!op_q) rdata_d = bus.store_Q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          cs_n_d  = 1'b1;
          rsp_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= 32'd0;
      cs_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      rsp_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready  = rdy_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.store_A    = addr_q;
  assign bus.store_D    = data_q;
  assign bus.store_CS_n = cs_n_q;
  assign bus.store_WE_n = we_n_q;
  assign bus.store_OE_n = oe_n_q;
endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: default and 2/3/2 timing instances,
// each with a store model and a transaction-timeline reference.
module tb_store_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_sequencer_if b0 ();
  store_sequencer_if b1 ();

  store_sequencer #(
    .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
  ) dut0 (.clk(clk), .reset(reset), .bus(b0));

  store_sequencer #(
    .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)
  ) dut1 (.clk(clk), .reset(reset), .bus(b1));

  localparam int SS [2] = '{1, 2};
  localparam int TT [2] = '{2, 3};
  localparam int HH [2] = '{1, 2};

  int n_chk = 0;
  int n_fail = 0;

  logic        rv [2];
  logic        rw [2];
  logic [4:0]  ra [2];
  logic [31:0] rd [2];

  assign b0.req_valid = rv[0];
  assign b0.req_write = rw[0];
  assign b0.req_addr  = ra[0];
  assign b0.req_wdata = rd[0];
  assign b1.req_valid = rv[1];
  assign b1.req_write = rw[1];
  assign b1.req_addr  = ra[1];
  assign b1.req_wdata = rd[1];

  logic        o_rdy [2];
  logic        o_busy [2];
  logic        o_rsp [2];
  logic [31:0] o_rdata [2];
  logic [4:0]  o_a [2];
  logic [31:0] o_d [2];
  logic        o_cs [2];
  logic        o_we [2];
  logic        o_oe [2];

  assign o_rdy[0]   = b0.req_ready;
  assign o_busy[0]  = b0.busy;
  assign o_rsp[0]   = b0.rsp_valid;
  assign o_rdata[0] = b0.rsp_rdata;
  assign o_a[0]     = b0.store_A;
  assign o_d[0]     = b0.store_D;
  assign o_cs[0]    = b0.store_CS_n;
  assign o_we[0]    = b0.store_WE_n;
  assign o_oe[0]    = b0.store_OE_n;
  assign o_rdy[1]   = b1.req_ready;
  assign o_busy[1]  = b1.busy;
  assign o_rsp[1]   = b1.rsp_valid;
  assign o_rdata[1] = b1.rsp_rdata;
  assign o_a[1]     = b1.store_A;
  assign o_d[1]     = b1.store_D;
  assign o_cs[1]    = b1.store_CS_n;
  assign o_we[1]    = b1.store_WE_n;
  assign o_oe[1]    = b1.store_OE_n;

  // 2114-like store: write lands on the rising edge of WE_n
  bit [31:0] smem0 [32];
  bit [31:0] smem1 [32];

  initial forever begin
    @(posedge b0.store_WE_n);
    if (b0.store_CS_n === 1'b0) smem0[b0.store_A] = b0.store_D;
  end
  initial forever begin
    @(posedge b1.store_WE_n);
    if (b1.store_CS_n === 1'b0) smem1[b1.store_A] = b1.store_D;
  end

  assign b0.store_Q = (!b0.store_CS_n && !b0.store_OE_n) ?
                      smem0[b0.store_A] : 32'h0BADF00D;
  assign b1.store_Q = (!b1.store_CS_n && !b1.store_OE_n) ?
                      smem1[b1.store_A] : 32'h0BADF00D;

  // Reference: k = clock edges since the accepting edge
  bit          act [2];
  int          k [2];
  bit          mop [2];
  logic [4:0]  ma [2];
  logic [31:0] md [2];
  logic [31:0] xr [2];
  bit          xrk [2];
  bit [31:0]   emem [2][32];
  bit          ekn [2][32];

  initial forever begin
    @(posedge clk or posedge reset);
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        if (act[l] && mop[l] && k[l] < SS[l] + TT[l])
          ekn[l][ma[l]] = 1'b0;
        act[l] = 1'b0;
        k[l]   = 0;
        xr[l]  = 32'd0;
        xrk[l] = 1'b1;
      end else if (act[l]) begin
        k[l] = k[l] + 1;
        if (k[l] == SS[l] + TT[l] && !mop[l]) begin
          xr[l]  = emem[l][ma[l]];
          xrk[l] = ekn[l][ma[l]];
        end
        if (k[l] > SS[l] + TT[l] + HH[l]) act[l] = 1'b0;
      end else if (rv[l] === 1'b1) begin
        act[l] = 1'b1;
        k[l]   = 0;
        mop[l] = rw[l];
        ma[l]  = ra[l];
        md[l]  = rd[l];
        if (rw[l]) begin
          emem[l][ra[l]] = rd[l];
          ekn[l][ra[l]]  = 1'b1;
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the reference timeline
  logic        p_cs [2];
  logic [4:0]  p_a [2];
  logic [31:0] p_d [2];

  initial forever begin
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      int  s, t, h;
      bit  e_cs, e_we, e_oe, e_rsp, e_busy, strobe;
      string pf;
      pf = $sformatf("lane%0d", l);
      s = SS[l]; t = TT[l]; h = HH[l];
      strobe = act[l] && k[l] >= s && k[l] < s + t;
      e_busy = act[l];
      e_rsp  = act[l] && k[l] == s + t + h;
      e_cs   = !act[l] || e_rsp;
      e_we   = !(strobe && mop[l]);
      e_oe   = !(strobe && !mop[l]);
      chk({pf, " req_ready"}, o_rdy[l], !e_busy);
      chk({pf, " busy"}, o_busy[l], e_busy);
      chk({pf, " rsp_valid"}, o_rsp[l], e_rsp);
      chk({pf, " CS_n"}, o_cs[l], e_cs);
      chk({pf, " WE_n"}, o_we[l], e_we);
      chk({pf, " OE_n"}, o_oe[l], e_oe);
      if (!e_cs) begin
        chk({pf, " store_A"}, o_a[l], ma[l]);
        chk({pf, " store_D"}, o_d[l], md[l]);
      end
      if (xrk[l]) chk({pf, " rsp_rdata"}, o_rdata[l], xr[l]);
      chk({pf, " WE_n/OE_n exclusive"}, o_we[l] | o_oe[l], 1'b1);
      if (p_cs[l] === 1'b0 && o_cs[l] === 1'b0) begin
        chk({pf, " A stable under CS"}, o_a[l], p_a[l]);
        chk({pf, " D stable under CS"}, o_d[l], p_d[l]);
      end
      p_cs[l] = o_cs[l];
      p_a[l]  = o_a[l];
      p_d[l]  = o_d[l];
    end
  end

  task automatic issue(int l, bit w, bit [4:0] a, bit [31:0] d);
    @(negedge clk);
    rv[l] = 1'b1;
    rw[l] = w;
    ra[l] = a;
    rd[l] = d;
    for (int i = 0; i < 100 && o_rdy[l] !== 1'b1; i++) @(negedge clk);
    chk($sformatf("lane%0d accept", l), o_rdy[l], 1'b1);
    if (o_rdy[l] !== 1'b1) rv[l] = 1'b0;
    else @(posedge clk);
  endtask

  task automatic wait_rsp(int l, output int lat, output int wel,
                          output logic [31:0] rdat);
    lat = 0;
    wel = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_we[l] === 1'b0) wel++;
      if (o_rsp[l] === 1'b1) break;
    end
    rdat = o_rdata[l];
    chk($sformatf("lane%0d rsp seen", l), o_rsp[l], 1'b1);
  endtask

  task automatic run(int l, bit w, bit [4:0] a, bit [31:0] d,
                     output int lat, output int wel,
                     output logic [31:0] rdat);
    issue(l, w, a, d);
    @(negedge clk);
    rv[l] = 1'b0;
    wait_rsp(l, lat, wel, rdat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wel, elat, ewel;
    logic [31:0] rdat;
    for (int l = 0; l < 2; l++) begin
      rv[l] = 1'b0; rw[l] = 1'b0; ra[l] = 5'd0; rd[l] = 32'd0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset req_ready", o_rdy[0], 1'b1);
    chk("reset busy", o_busy[0], 1'b0);
    chk("reset rsp_valid", o_rsp[0], 1'b0);
    chk("reset rsp_rdata", o_rdata[0], 32'd0);
    chk("reset store_A", o_a[0], 5'd0);
    chk("reset store_D", o_d[0], 32'd0);
    chk("reset CS_n", o_cs[0], 1'b1);
    chk("reset WE_n", o_we[0], 1'b1);
    chk("reset OE_n", o_oe[0], 1'b1);
    chk("reset lane1 CS_n", o_cs[1], 1'b1);
    reset = 1'b0;

    for (int l = 0; l < 2; l++) begin
      elat = (l == 0) ? 4 : 7;
      ewel = (l == 0) ? 2 : 3;
      run(l, 1, 5'd5, 32'hDEADBEEF, lat, wel, rdat);
      chk($sformatf("lane%0d write latency", l), lat, elat);
      chk($sformatf("lane%0d WE_n low cycles", l), wel, ewel);
      run(l, 0, 5'd5, 32'h0, lat, wel, rdat);
      chk($sformatf("lane%0d read latency", l), lat, elat);
      chk($sformatf("lane%0d read addr5", l), rdat, 32'hDEADBEEF);
      chk($sformatf("lane%0d read WE_n low", l), wel, 0);
      run(l, 1, 5'd0, 32'h00000001, lat, wel, rdat);
      run(l, 1, 5'd31, 32'h80000000, lat, wel, rdat);
      run(l, 0, 5'd0, 32'h0, lat, wel, rdat);
      chk($sformatf("lane%0d read addr0", l), rdat, 32'h00000001);
      run(l, 0, 5'd31, 32'h0, lat, wel, rdat);
      chk($sformatf("lane%0d read addr31", l), rdat, 32'h80000000);
      run(l, 1, 5'd3, 32'h33333333, lat, wel, rdat);
      run(l, 1, 5'd4, 32'h12345678, lat, wel, rdat);
      // write to addr 4 is presented while the read of addr 3 is busy
      issue(l, 0, 5'd3, 32'h0);
      issue(l, 1, 5'd4, 32'h44444444);
      @(negedge clk);
      rv[l] = 1'b0;
      wait_rsp(l, lat, wel, rdat);
      run(l, 0, 5'd3, 32'h0, lat, wel, rdat);
      chk($sformatf("lane%0d read addr3", l), rdat, 32'h33333333);
      run(l, 0, 5'd4, 32'h0, lat, wel, rdat);
      chk($sformatf("lane%0d read addr4", l), rdat, 32'h44444444);
    end

    // Reset in the first strobe cycle of a write to addr 7
    issue(0, 1, 5'd7, 32'h77777777);
    @(negedge clk);
    rv[0] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort WE_n", o_we[0], 1'b1);
    chk("abort CS_n", o_cs[0], 1'b1);
    chk("abort OE_n", o_oe[0], 1'b1);
    chk("abort busy", o_busy[0], 1'b0);
    chk("abort req_ready", o_rdy[0], 1'b1);
    chk("abort rsp_valid", o_rsp[0], 1'b0);
    chk("abort rsp_rdata", o_rdata[0], 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run(0, 0, 5'd7, 32'h0, lat, wel, rdat);
    chk("post-abort read latency", lat, 4);

    for (int l = 0; l < 2; l++) begin
      for (int n = 0; n < 60; n++) begin
        issue(l, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              32'($urandom));
        if ($urandom_range(0, 1) == 0) begin
          @(negedge clk);
          rv[l] = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      @(negedge clk);
      rv[l] = 1'b0;
      repeat (12) @(negedge clk);
      for (int a = 0; a < 32; a += 7) begin
        run(l, 0, 5'(a), 32'h0, lat, wel, rdat);
      end
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Initiator-side controller for the 32 x 32-bit store lines. Accepts single-word read/write requests from the control unit over a valid/ready handshake and drives the store's address, data, CS_n, WE_n and OE_n pins with a glitch-free setup/strobe/hold sequence that respects 2114 timing. Captures read data from the store output bus and returns it with a one-cycle response pulse. Sits between the Baby control unit and the store lines block.

Parameters:
SETUP_CYCLES, 1, cycles address/data/CS_n are stable before the strobe (1..15)
STROBE_CYCLES, 2, width of WE_n low pulse (write) or OE_n access window (read) (1..15)
HOLD_CYCLES, 1, cycles address/data/CS_n are held after the strobe ends (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  5  store line number 0..31
req_wdata  in  32  write data
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_rdata  out  32  read data, valid when rsp_valid is high after a read
busy  out  1  transaction in progress (not IDLE)
store_A  out  5  store line address
store_D  out  32  data to store
store_CS_n  out  1  store chip select, active low
store_WE_n  out  1  store write enable, active low
store_OE_n  out  1  store output enable, active low
store_Q  in  32  data from store

Behaviour:
- One clock (clk); reset asynchronous, active-high. All outputs registered.
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, store_A=0, store_D=0, store_CS_n=1, store_WE_n=1, store_OE_n=1; state IDLE.
- States: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
- IDLE: req_ready=1, CS_n/WE_n/OE_n all 1. Accept on rising edge with req_valid & req_ready. At that edge, latch addr/wdata/write into store_A/store_D/op, assert CS_n=0, go SETUP, req_ready=0, busy=1.
- SETUP: SETUP_CYCLES cycles. CS_n=0, WE_n=1, OE_n=1; A and D stable.
- STROBE: STROBE_CYCLES cycles.
  - Write: WE_n=0, OE_n=1.
  - Read: WE_n=1, OE_n=0.
  - On the edge ending the last STROBE cycle of a read, capture store_Q into rsp_rdata.
- HOLD: HOLD_CYCLES cycles. WE_n=1, OE_n=1, CS_n=0; A and D still held.
- DONE: one cycle. CS_n=1, rsp_valid=1 for reads and writes. Return to IDLE at next edge.
- rsp_rdata is unchanged by writes and holds its value until the next read capture.
- Invariants:
  - store_A and store_D never change while CS_n=0.
  - WE_n and OE_n are never low simultaneously.
  - WE_n is never low in SETUP, HOLD, DONE or IDLE.
- Latency: with accept at edge E0, rsp_valid rises at edge E0+S+T+H (defaults: E0+4) for exactly 1 cycle. req_ready rises at E0+S+T+H+1.
- Back-to-back: next request can be accepted at the edge where req_ready is first sampled high, i.e. no overlap.
- req_valid while req_ready=0 is ignored; no queuing. Requester holds the request until accepted.
- Addresses 0 and 31 are ordinary; no wrap or bounds logic.
- Phase counter width is 4 bits. Each phase's count reloads on entry, so a parameter value of N gives exactly N cycles.
- Reset mid-transaction:
  - Strobes deassert immediately (asynchronous) and the transaction is discarded.
  - No rsp_valid; rsp_rdata returns to 0.
  - A write aborted during STROBE may leave the store line undefined.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs at reset values immediately; CS_n=WE_n=OE_n=1, req_ready=1.
- Write then read: write addr 5 data 0xDEADBEEF, then read addr 5 (store model attached). Write: WE_n low exactly 2 cycles with A=5 stable from SETUP through HOLD. Read: rsp_valid at E0+4 with rsp_rdata=0xDEADBEEF.
- Boundaries: write 0x00000001 to addr 0 and 0x80000000 to addr 31, then read both -> each returns its own value; no aliasing.
- Busy rejection: req_valid held high for a read of addr 3, and a second request (write addr 4) is presented while busy -> second request is not accepted until req_ready returns. Exactly one rsp_valid per accepted request; addr 4 is unmodified until its own accept.
- Parameters: SETUP=2, STROBE=3, HOLD=2 -> rsp_valid at E0+7. A 32-cycle checker sees no cycle with WE_n=0 and OE_n=0, and no A/D change while CS_n=0.
- Reset during a write STROBE to addr 7 -> WE_n high immediately, no rsp_valid, busy=0. A following read of addr 7 completes normally with a rsp_valid pulse.
